isdft_sum: RTL and testbench

Inverse reconstruction stage for the sliding-DFT block stream. It consumes one frequency-domain block per sample tick (sob/eob/valid framed, real part in the low IDW bits) and sums the real parts of all bins. It scales the sum by 1/N and emits one reconstructed time-domain sample per block. It sits downstream of the SDFT and any frequency-domain processing, and closes the analysis → processing → synthesis loop. It also flags framing violations.

---
 rtl/sdft_pkg.sv | 20 ++
 rtl/sat_sdft.sv | 32 +++
 rtl/isdft_sum.sv | 174 +++++++++++++++++
 tb/tb_isdft_sum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// Shared types and elaboration-time helpers for the sliding-DFT block family.
package sdft_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Signed accumulator width for summing one block of IDW-bit bins:
    // log2(N) growth for N terms plus 1 for the x2 half-spectrum weight plus 1 spare.
    function automatic int unsigned acc_width(input int unsigned idw, input int unsigned n);
        return idw + $clog2(n) + 2;
    endfunction

    // Index of the final bin of a block.
    function automatic int unsigned last_bin(input int unsigned n, input bit half);
        return half ? (n / 2) - 1 : n - 1;
    endfunction

endpackage

// File: rtl/sat_sdft.sv
// Signed clip of an IW-bit value to OW bits, flagging when clipping occurred.
module sat_sdft #(
    parameter int IW = 18,
    parameter int OW = 16
) (
    input  logic [IW-1:0] data_i,
    output logic [OW-1:0] data_o,
    output logic          sat_o
);

    generate
        if (IW > OW) begin : g_clip
            logic [IW-OW:0] top_bits;
            assign top_bits = data_i[IW-1:OW-1];

            // Value fits only when all bits above the output sign bit match it.
            always_comb begin
                data_o = data_i[OW-1:0];
                sat_o  = 1'b0;
                if (!((&top_bits) || !(|top_bits))) begin
                    sat_o  = 1'b1;
                    data_o = data_i[IW-1] ? {1'b1, {(OW-1){1'b0}}}
                                          : {1'b0, {(OW-1){1'b1}}};
                end
            end
        end else begin : g_ext
            assign data_o = OW'($signed(data_i));
            assign sat_o  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/isdft_sum.sv
// Inverse SDFT reconstruction: sums the real parts of one frequency block,
// scales by 1/N with round-half-up, clips to DW and emits one sample per block.
module isdft_sum
    import sdft_pkg::*;
#(
    parameter int N        = 4096,
    parameter int IDW      = 32,
    parameter int IMAG_EN  = 1,
    parameter int IW       = IMAG_EN ? IDW * 2 : IDW,
    parameter     SPECTRUM = "full",
    parameter int DW       = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [IW-1:0] data_i,
    input  logic          sob_i,
    input  logic          eob_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          frame_err_o,
    output logic          sat_alarm_o
);

    localparam int LOG2N = $clog2(N);
    localparam bit HALF  = (SPECTRUM == "half");
    localparam int ACC_W = acc_width(IDW, N);
    localparam int CNT_W = LOG2N + 1;
    localparam int RED_W = ACC_W - LOG2N;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_bin(N, HALF));
    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2 ** (LOG2N - 1));

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic take, first, done, ferr;

    logic signed [ACC_W-1:0] real_ext, term_d, term_q, acc_q, sum_rnd;
    logic term_vld_q, term_first_q, term_done_q, acc_done_q;
    logic [RED_W-1:0] red;
    logic [DW-1:0]    sat_data;
    logic             sat_flag;

    generate
        if (IW > IDW) begin : g_imag
            logic unused_imag;
            assign unused_imag = ^data_i[IW-1:IDW];
        end
    endgenerate

    assign real_ext = {{(ACC_W-IDW){data_i[IDW-1]}}, data_i[IDW-1:0]};

    // Framing state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Framing decisions on the incoming beat: accept, restart, complete or reject.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        first   = 1'b0;
        done    = 1'b0;
        ferr    = 1'b0;
        if (valid_i) begin
            if (sob_i) begin
                // sob always starts a fresh block; in ACCUM the partial sum is abandoned.
                ferr    = (state_q == ACCUM);
                take    = 1'b1;
                first   = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = ACCUM;
                if (eob_i) begin
                    ferr    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end else if (state_q == ACCUM) begin
                take = 1'b1;
                if (eob_i || cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (eob_i && cnt_q == LAST) begin
                        done = 1'b1;
                    end else begin
                        ferr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ferr = 1'b1;
            end
        end
    end

    // Bin weighting: half spectrum counts every non-DC bin twice.
    always_comb begin
        term_d = real_ext;
        if (HALF && !first) begin
            term_d = real_ext <<< 1;
        end
    end

    // Stage 1: register the weighted term with its framing tags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            term_q       <= '0;
            term_vld_q   <= 1'b0;
            term_first_q <= 1'b0;
            term_done_q  <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            term_vld_q   <= take;
            term_first_q <= first;
            term_done_q  <= done;
            frame_err_o  <= ferr;
            if (take) begin
                term_q <= term_d;
            end
        end
    end

    // Stage 2: accumulate; the first term of a block overwrites instead of adding.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q      <= '0;
            acc_done_q <= 1'b0;
        end else begin
            acc_done_q <= term_vld_q & term_done_q;
            if (term_vld_q) begin
                acc_q <= term_first_q ? term_q : acc_q + term_q;
            end
        end
    end

    // Round half up, then divide by N by dropping the low LOG2N bits.
    assign sum_rnd = acc_q + ROUND;
    assign red     = sum_rnd[ACC_W-1:LOG2N];

    logic unused_frac;
    assign unused_frac = ^sum_rnd[LOG2N-1:0];

    sat_sdft #(
        .IW (RED_W),
        .OW (DW)
    ) u_sat (
        .data_i (red),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    // Stage 3: register the clipped sample for completed blocks only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            sat_alarm_o <= 1'b0;
        end else begin
            valid_o     <= acc_done_q;
            sat_alarm_o <= acc_done_q & sat_flag;
            if (acc_done_q) begin
                data_o <= sat_data;
            end
        end
    end

endmodule

// File: tb/tb_isdft_sum.sv
// Self-checking bench for isdft_sum: three N=8 instances (full/16-bit with imag,
// half/16-bit, full/8-bit), table-driven blocks plus framing and reset sequences.
module tb_isdft_sum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] d0;
    logic [31:0] d1;
    logic [15:0] d2;
    logic sob [3];
    logic eob [3];
    logic vin [3];
    logic [15:0] q0, q1;
    logic [7:0]  q2;
    logic vo [3];
    logic fe [3];
    logic sa [3];

    isdft_sum #(.N(8), .IDW(32), .IMAG_EN(1), .SPECTRUM("full"), .DW(16)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d0), .sob_i(sob[0]), .eob_i(eob[0]),
        .valid_i(vin[0]), .data_o(q0), .valid_o(vo[0]), .frame_err_o(fe[0]),
        .sat_alarm_o(sa[0]));

    isdft_sum #(.N(8), .IDW(32), .IMAG_EN(0), .SPECTRUM("half"), .DW(16)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d1), .sob_i(sob[1]), .eob_i(eob[1]),
        .valid_i(vin[1]), .data_o(q1), .valid_o(vo[1]), .frame_err_o(fe[1]),
        .sat_alarm_o(sa[1]));

    isdft_sum #(.N(8), .IDW(16), .IMAG_EN(0), .SPECTRUM("full"), .DW(8)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d2), .sob_i(sob[2]), .eob_i(eob[2]),
        .valid_i(vin[2]), .data_o(q2), .valid_o(vo[2]), .frame_err_o(fe[2]),
        .sat_alarm_o(sa[2]));

    typedef struct {
        int dut;
        int due;
        int data;
        bit sat;
    } exp_t;

    typedef struct {
        int dut;
        int due;
    } ferr_t;

    typedef struct {
        int dut;
        int nb;
        int re [8];
        int exp;
        bit sat;
        bit rimag;
    } vec_t;

    exp_t  oq [$];
    ferr_t fq [$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outval(input int k);
        int r;
        case (k)
            0:       r = int'($signed(q0));
            1:       r = int'($signed(q1));
            default: r = int'($signed(q2));
        endcase
        return r;
    endfunction

    // Scoreboard: match every output/frame-error pulse against the expectation queues.
    always @(negedge clk) begin
        int idx;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (vo[k]) begin
                    idx = -1;
                    foreach (oq[i]) if (idx < 0 && oq[i].dut == k) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_valid_dut%0d", k), 1, 0);
                    end else begin
                        chk($sformatf("latency_dut%0d", k), cyc, oq[idx].due);
                        chk($sformatf("data_dut%0d", k), outval(k), oq[idx].data);
                        chk($sformatf("sat_dut%0d", k), int'(sa[k]), int'(oq[idx].sat));
                        oq.delete(idx);
                    end
                end else if (sa[k]) begin
                    chk($sformatf("sat_without_valid_dut%0d", k), 1, 0);
                end
                if (fe[k]) begin
                    idx = -1;
                    foreach (fq[i]) if (idx < 0 && fq[i].dut == k) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_frame_err_dut%0d", k), 1, 0);
                    end else begin
                        chk($sformatf("frame_err_timing_dut%0d", k), cyc, fq[idx].due);
                        fq.delete(idx);
                    end
                end
            end
            for (int i = oq.size() - 1; i >= 0; i--) begin
                if (oq[i].due < cyc) begin
                    chk($sformatf("valid_timeout_dut%0d", oq[i].dut), 0, 1);
                    oq.delete(i);
                end
            end
            for (int i = fq.size() - 1; i >= 0; i--) begin
                if (fq[i].due < cyc) begin
                    chk($sformatf("frame_err_missing_dut%0d", fq[i].dut), 0, 1);
                    fq.delete(i);
                end
            end
        end
    end

    task automatic expect_out(input int k, input int data, input bit sat);
        exp_t e;
        e.dut = k; e.due = cyc + 3; e.data = data; e.sat = sat;
        oq.push_back(e);
    endtask

    task automatic expect_ferr(input int k);
        ferr_t f;
        f.dut = k; f.due = cyc + 1;
        fq.push_back(f);
    endtask

    task automatic beat(input int k, input logic [63:0] d, input bit s, input bit e);
        case (k)
            0:       d0 = d;
            1:       d1 = d[31:0];
            default: d2 = d[15:0];
        endcase
        sob[k] = s;
        eob[k] = e;
        vin[k] = 1'b1;
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
        sob[k] = 1'b0;
        eob[k] = 1'b0;
    endtask

    task automatic block(input vec_t v, input int gap);
        logic [63:0] d;
        for (int b = 0; b < v.nb; b++) begin
            d[63:32] = v.rimag ? $urandom() : 32'h0;
            d[31:0]  = v.re[b];
            if (b == v.nb - 1) expect_out(v.dut, v.exp, v.sat);
            beat(v.dut, d, b == 0, b == v.nb - 1);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    vec_t vt [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        d0 = '0; d1 = '0; d2 = '0;
        for (int k = 0; k < 3; k++) begin
            sob[k] = 1'b0; eob[k] = 1'b0; vin[k] = 1'b0;
        end

        vt[0]  = '{0, 8, '{8, 8, 8, 8, 8, 8, 8, 8}, 8, 1'b0, 1'b1};
        vt[1]  = '{1, 4, '{16, 8, 8, 8, 0, 0, 0, 0}, 8, 1'b0, 1'b0};
        vt[2]  = '{0, 8, '{12, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b0, 1'b1};
        vt[3]  = '{0, 8, '{-12, 0, 0, 0, 0, 0, 0, 0}, -1, 1'b0, 1'b0};
        vt[4]  = '{0, 8, '{0, 0, 0, 5, 6, 0, 0, 0}, 1, 1'b0, 1'b0};
        vt[5]  = '{2, 8, '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000}, 127, 1'b1, 1'b0};
        vt[6]  = '{2, 8, '{-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000}, -128, 1'b1, 1'b0};
        vt[7]  = '{0, 8, '{100, -50, 7, 3, 0, -1, 20, 5}, 11, 1'b0, 1'b1};
        vt[8]  = '{1, 4, '{-5, 10, -3, 1, 0, 0, 0, 0}, 1, 1'b0, 1'b0};
        vt[9]  = '{2, 8, '{127, 127, 127, 127, 127, 127, 127, 127}, 127, 1'b0, 1'b0};
        vt[10] = '{2, 8, '{-128, -128, -128, -128, -128, -128, -128, -128}, -128, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("reset_data", outval(0), 0);
        chk("reset_valid", int'(vo[0]), 0);
        chk("reset_frame_err", int'(fe[0]), 0);
        chk("reset_sat", int'(sa[0]), 0);

        // Table blocks, issued back to back with no bubble.
        for (int i = 0; i < 11; i++) block(vt[i], 0);

        // eob on the fifth beat of a full block.
        for (int b = 0; b < 5; b++) begin
            if (b == 4) expect_ferr(0);
            beat(0, 64'd3, b == 0, b == 4);
        end

        // sob arriving on beat 3 restarts with a clean block.
        for (int b = 0; b < 3; b++) beat(0, 64'd9, b == 0, 1'b0);
        expect_ferr(0);
        block(vt[7], 0);

        // Gaps inside a block leave the result unchanged.
        block(vt[7], 2);
        block(vt[1], 1);

        // valid without sob while idle.
        expect_ferr(0);
        beat(0, 64'd5, 1'b0, 1'b0);

        // Last bin without eob.
        for (int b = 0; b < 8; b++) begin
            if (b == 7) expect_ferr(0);
            beat(0, 64'd4, b == 0, 1'b0);
        end

        repeat (6) begin
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a block clears outputs at once.
        for (int b = 0; b < 4; b++) beat(0, 64'd100, b == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_data0", outval(0), 0);
        chk("midreset_data2", outval(2), 0);
        chk("midreset_valid", int'(vo[0]), 0);
        chk("midreset_frame_err", int'(fe[0]), 0);
        chk("midreset_sat", int'(sa[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        block(vt[0], 0);

        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("queues_drained", oq.size() + fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
